// File: rtl/ahbslv_wbmas_top.sv
// AHB-Lite slave to Wishbone classic master bridge. Every accepted AHB beat
// becomes one single Wishbone cycle; wait states stretch the AHB data phase.
module ahbslv_wbmas_top #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255,
  parameter int TOWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hsel,
  input  logic [AWIDTH-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DWIDTH-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic [DWIDTH-1:0] hrdata,
  output logic [AWIDTH-1:0] adr_o,
  output logic [DWIDTH-1:0] dat_o,
  input  logic [DWIDTH-1:0] dat_i,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [3:0]        sel_o,
  input  logic              ack_i,
  input  logic              err_i
);

  typedef enum logic [2:0] {IDLE, CYC, DONE, ERR1, ERR2} state_t;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic              write;
    logic [1:0]        size;
  } req_t;

  localparam logic [TOWIDTH-1:0] TO_LAST = TOWIDTH'(TIMEOUT - 1);

  state_t               state, state_nxt;
  req_t                 req_q;
  logic [TOWIDTH-1:0]   to_cnt;
  logic [3:0]           sel_dec;
  logic                 accept, size_bad, to_hit, rd_done;
  logic                 unused_in;

  // hburst is deliberately ignored: each beat is handled as a single transfer.
  assign unused_in = ^{hburst, htrans[0]};

  assign accept   = (state inside {IDLE, DONE, ERR2}) & hsel & hready & htrans[1];
  assign size_bad = hsize > 3'b010;
  assign to_hit   = (TIMEOUT != 0) && (to_cnt == TO_LAST);
  assign rd_done  = (state == CYC) & ack_i & ~err_i & ~req_q.write;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE, ERR2: state_nxt = !accept ? IDLE : (size_bad ? ERR1 : CYC);
      CYC: begin
        if (err_i)       state_nxt = ERR1;
        else if (ack_i)  state_nxt = DONE;
        else if (to_hit) state_nxt = ERR1;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q  <= '0;
      hrdata <= '0;
      to_cnt <= '0;
    end else begin
      if (accept) req_q <= '{addr: haddr, write: hwrite, size: hsize[1:0]};
      if (rd_done) hrdata <= dat_i;
      // Counts CYC cycles; zero on the first one.
      to_cnt <= (state == CYC) ? to_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    unique case (req_q.size)
      2'b00:   sel_dec = 4'b0001 << req_q.addr[1:0];
      2'b01:   sel_dec = req_q.addr[1] ? 4'b1100 : 4'b0011;
      default: sel_dec = 4'b1111;
    endcase
  end

  always_comb begin
    cyc_o     = 1'b0;
    stb_o     = 1'b0;
    we_o      = 1'b0;
    adr_o     = '0;
    sel_o     = '0;
    dat_o     = '0;
    hreadyout = 1'b1;
    hresp     = 2'b00;
    unique case (state)
      CYC: begin
        cyc_o     = 1'b1;
        stb_o     = 1'b1;
        we_o      = req_q.write;
        adr_o     = req_q.addr;
        sel_o     = sel_dec;
        hreadyout = 1'b0;
        // AHB keeps hwdata stable while hreadyout is low, so pass it straight through.
        if (req_q.write) dat_o = hwdata;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 2'b01;
      end
      ERR2:    hresp = 2'b01;
      default: ;
    endcase
  end

endmodule
